// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
//
// Walks a register file through its asynchronous read port and streams each
// register as an {address, data} word over a valid/ready handshake. The range
// runs from first_addr up to last_addr inclusive and wraps through the top
// index when first_addr > last_addr.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   rst        - asynchronous, active-low reset
//   start      - dump request, only honoured while idle
//   abort      - cancels a dump in progress (no done pulse)
//   first_addr - first register index, latched when start is accepted
//   last_addr  - last register index, latched when start is accepted
//   rd_addr    - register-file read address (always the current pointer)
//   rd_data    - combinational read data for rd_addr
//   out_valid  - out_addr/out_data hold a word
//   out_ready  - consumer accepts the word on the next edge
//   out_addr   - register index of the presented word
//   out_data   - register contents of the presented word
//   busy       - high whenever the block is not idle
//   done       - one-cycle pulse after the last word has been accepted
// -----------------------------------------------------------------------------
module regfile_dump #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;

    // Next-state and datapath decode; every path starts from "hold".
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        end_d       = end_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous abort here: abort only
                // cancels dumps that are already running.
                if (start) begin
                    cur_d   = first_addr;
                    end_d   = last_addr;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FETCH: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    // rd_data is sampled at this edge, so a same-edge write
                    // to the register file is not yet visible.
                    out_data_d  = rd_data;
                    out_addr_d  = cur_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_SEND;
                end
            end

            ST_SEND: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (cur_q == end_q) begin
                        state_d = ST_DONE;
                    end else begin
                        // Natural ADDR_W-bit overflow gives the wrap to 0.
                        cur_d   = cur_q + ADDR_ONE;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= ADDR_ZERO;
            end_q       <= ADDR_ZERO;
            out_addr_q  <= ADDR_ZERO;
            out_data_q  <= DATA_ZERO;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            end_q       <= end_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Outputs come straight from registers or from the state register only,
    // so nothing combinational reaches them from out_ready or abort.
    assign rd_addr   = cur_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic          out_ready  = 1'b1;
    logic [AW-1:0] first_addr = 5'd0;
    logic [AW-1:0] last_addr  = 5'd0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    // register-file model: r[i] = i * 0x11111111, plus one overridable entry
    logic          we    = 1'b0;
    logic [AW-1:0] wa    = 5'd0;
    logic [DW-1:0] wd    = 32'd0;
    logic          ov_en = 1'b0;

    int cmp_n = 0;
    int err_n = 0;

    typedef struct {
        logic [4:0]  first;
        logic [4:0]  last;
        int          exp_words;
        logic [4:0]  exp_last_addr;
        logic [31:0] exp_last_data;
        int          stall_word;
        bit          poke;
    } vec_t;

    vec_t vecs [7];

    regfile_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [4:0] a);
        logic [31:0] x;
        x = {27'd0, a};
        return x * 32'h11111111;
    endfunction

    always @(posedge clk) ov_en <= we;

    assign rd_data = (ov_en && rd_addr == wa) ? wd : model(rd_addr);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Let any running dump finish with out_ready=1, bounded.
    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_dump(input vec_t v);
        int          j, stalls, cyc, done_cyc, exp_done;
        bit          fin;
        logic [4:0]  e, la, sa;
        logic [31:0] ld, sd;
        j = 0; stalls = 0; cyc = 0; done_cyc = -1; fin = 1'b0;
        la = 5'd0; ld = 32'd0; sa = 5'd0; sd = 32'd0;
        @(negedge clk);
        first_addr = v.first; last_addr = v.last; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("valid_after_start", {63'd0, out_valid}, 64'd0);
        while (!fin && cyc < 200) begin
            if (out_valid) begin
                if (j == v.stall_word && stalls < 5) begin
                    if (stalls == 0) begin
                        sa = out_addr; sd = out_data;
                    end else begin
                        chk("stall_addr", {59'd0, out_addr}, {59'd0, sa});
                        chk("stall_data", {32'd0, out_data}, {32'd0, sd});
                    end
                    out_ready = 1'b0;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                    e = v.first + j[4:0];
                    chk("word_addr", {59'd0, out_addr}, {59'd0, e});
                    chk("word_data", {32'd0, out_data}, {32'd0, model(e)});
                    la = out_addr; ld = out_data;
                    j++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end
            if (v.poke && cyc == 2) begin
                start = 1'b1; first_addr = 5'd20; last_addr = 5'd25;
            end else begin
                start = 1'b0;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) chk("latency_valid", {63'd0, out_valid}, 64'd1);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        exp_done = 2 * v.exp_words + ((v.stall_word >= 0) ? 5 : 0);
        chk("dump_finished", {63'd0, fin}, 64'd1);
        chk("word_count", 64'(j), 64'(v.exp_words));
        chk("last_addr", {59'd0, la}, {59'd0, v.exp_last_addr});
        chk("last_data", {32'd0, ld}, {32'd0, v.exp_last_data});
        chk("done_cycle", 64'(done_cyc), 64'(exp_done));
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("idle_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        vecs[0] = '{5'd3,  5'd5,  3,  5'd5,  32'h55555555, -1, 1'b0};
        vecs[1] = '{5'd30, 5'd1,  4,  5'd1,  32'h11111111, -1, 1'b0};
        vecs[2] = '{5'd7,  5'd7,  1,  5'd7,  32'h77777777, -1, 1'b0};
        vecs[3] = '{5'd31, 5'd0,  2,  5'd0,  32'h00000000, -1, 1'b0};
        vecs[4] = '{5'd0,  5'd31, 32, 5'd31, 32'h1111110F, -1, 1'b0};
        vecs[5] = '{5'd10, 5'd12, 3,  5'd12, 32'hCCCCCCCC, 1,  1'b0};
        vecs[6] = '{5'd3,  5'd5,  3,  5'd5,  32'h55555555, -1, 1'b1};

        // reset state, held across a few edges
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_addr", {59'd0, out_addr}, 64'd0);
        chk("rst_data", {32'd0, out_data}, 64'd0);
        chk("rst_rd_addr", {59'd0, rd_addr}, 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) run_dump(vecs[i]);

        // abort during the second word of a 0..31 dump
        @(negedge clk);
        first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(out_valid && out_addr == 5'd1) && n < 20) begin
            out_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("abort_reached_word1", {63'd0, (out_valid && out_addr == 5'd1)}, 64'd1);
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", {63'd0, seen}, 64'd0);
        run_dump(vecs[0]);

        // start and abort together in IDLE: start is taken
        @(negedge clk);
        first_addr = 5'd2; last_addr = 5'd2; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_beats_abort", {63'd0, busy}, 64'd1);
        drain();

        // a register-file write on the FETCH edge must not leak into out_data
        @(negedge clk);
        first_addr = 5'd9; last_addr = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        we = 1'b1; wa = 5'd9; wd = 32'hDEADBEEF;
        @(negedge clk);
        we = 1'b0;
        chk("wr_fetch_valid", {63'd0, out_valid}, 64'd1);
        chk("wr_fetch_addr", {59'd0, out_addr}, 64'd9);
        chk("wr_fetch_data", {32'd0, out_data}, 64'h99999999);
        chk("wr_fetch_rfupd", {32'd0, rd_data}, 64'hDEADBEEF);
        drain();
        @(negedge clk);

        // asynchronous reset between edges mid-dump
        @(negedge clk);
        first_addr = 5'd4; last_addr = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_addr", {59'd0, out_addr}, 64'd0);
        chk("arst_data", {32'd0, out_data}, 64'd0);
        chk("arst_rd_addr", {59'd0, rd_addr}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy || out_valid || done) seen = 1'b1;
        end
        chk("arst_stays_idle", {63'd0, seen}, 64'd0);
        run_dump(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
